// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory load path: access-size encodings,
// sequencer state type and the alignment/legality rule for a load.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A load is legal when its size is defined and the address is naturally aligned.
    function automatic logic load_legal(input logic [1:0] offset, input logic [1:0] size);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~offset[0];
            SZ_WORD: return (offset == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_lane_extender.sv
// Picks the byte/half lane of a little-endian memory word and sign- or
// zero-extends it to 32 bits; word loads pass straight through.
module load_lane_extender
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{offset, 3'b000} +: 8];
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        result    = rdata;
        case (size)
            SZ_BYTE: result = is_unsigned ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: result = is_unsigned ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_load_sequencer.sv
// Sequences one core load against a wait-stated data memory: word-aligned
// request, wait for ack (bounded by a timeout), then lane select and extension.
module mem_load_sequencer
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [1:0]            ld_size,
    input  logic                  ld_unsigned,
    output logic                  ld_ready,
    output logic                  stall,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  misalign,
    output logic                  timeout,
    output state_t                fsm_state
);

    // Core handshake: a load transfers on a cycle where ld_valid & ld_ready;
    // ld_valid must hold its payload until then, and ld_ready is high only in IDLE.

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   cnt_inc;
    logic            limit_hit;
    logic            accept;
    logic            legal;
    logic [1:0]      lat_offset;
    logic [1:0]      lat_size;
    logic            lat_unsigned;
    logic [31:0]     ext_data;

    assign fsm_state = state;
    assign legal     = load_legal(ld_addr[1:0], ld_size);
    assign cnt_inc   = wait_cnt + 1'b1;
    assign limit_hit = (cnt_inc == CW'(TIMEOUT_CYCLES));

    load_lane_extender u_ext (
        .rdata       (mem_rdata),
        .offset      (lat_offset),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .result      (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        stall      = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                ld_ready = 1'b1;
                accept   = ld_valid;
                stall    = ld_valid & legal;
                if (ld_valid && legal) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                // Ack on the cycle the limit is reached still completes the load.
                if (mem_ack) begin
                    state_next = ST_DONE;
                end else if (limit_hit) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt     <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            misalign     <= 1'b0;
            timeout      <= 1'b0;
            lat_offset   <= 2'b00;
            lat_size     <= SZ_BYTE;
            lat_unsigned <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            misalign <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept && legal) begin
                        lat_offset   <= ld_addr[1:0];
                        lat_size     <= ld_size;
                        lat_unsigned <= ld_unsigned;
                        mem_req      <= 1'b1;
                        mem_addr     <= {ld_addr[ADDR_WIDTH-1:2], 2'b00};
                        wait_cnt     <= '0;
                    end else if (accept) begin
                        misalign <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        rd_data  <= ext_data;
                        rd_valid <= 1'b1;
                        mem_req  <= 1'b0;
                    end else if (limit_hit) begin
                        timeout  <= 1'b1;
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_load_sequencer.sv
// Bench for mem_load_sequencer: directed vector table, hand-written corner
// sequences, and random loads checked against an arithmetic reference model.
module tb_mem_load_sequencer;
    import mips_mem_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        ld_unsigned;
    logic        ld_ready;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        misalign;
    logic        timeout;
    state_t      fsm_state;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_rd;
    logic [31:0] exp_q[$];

    mem_load_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .ld_ready    (ld_ready),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .misalign    (misalign),
        .timeout     (timeout),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_data;
        logic        exp_mis;
        logic        exp_to;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain shifts/masks and arithmetic sign extension.
    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns, input logic [31:0] rdata);
        logic [31:0] r;
        int unsigned off;
        off = addr % 4;
        if (size == 2'd0) begin
            r = (rdata >> (8 * off)) & 32'hFF;
            if (!uns && r >= 32'd128) r = r + 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            r = (rdata >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && r >= 32'd32768) r = r + 32'hFFFF_0000;
        end else begin
            r = rdata;
        end
        return r;
    endfunction

    function automatic logic ref_legal(input logic [31:0] addr, input logic [1:0] size);
        if (size == 2'd3) return 1'b0;
        if (size == 2'd1 && (addr % 2) != 0) return 1'b0;
        if (size == 2'd2 && (addr % 4) != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One full load: waits = REQ cycles without ack before the ack; waits >= TO means no ack.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] rdata, input int waits, input logic [31:0] exp_data,
                           input logic exp_mis, input logic exp_to);
        logic [31:0] aligned;
        logic [31:0] exp;
        aligned = {addr[31:2], 2'b00};
        tick();
        ld_valid    = 1'b1;
        ld_addr     = addr;
        ld_size     = size;
        ld_unsigned = uns;
        mem_ack     = 1'b0;
        #1;
        chk("accept_ld_ready", ld_ready, 1'b1);
        chk("accept_stall", stall, !exp_mis);
        tick();
        ld_valid = 1'b0;
        if (exp_mis) begin
            #1;
            chk("misalign_pulse", misalign, 1'b1);
            chk("misalign_no_req", mem_req, 1'b0);
            chk("misalign_stall", stall, 1'b0);
            chk("misalign_state", fsm_state, ST_IDLE);
            tick();
            chk("misalign_clear", misalign, 1'b0);
            chk("misalign_rd_hold", rd_data, last_rd);
            return;
        end
        for (int c = 1; c <= TO; c++) begin
            mem_ack   = (c - 1 == waits);
            mem_rdata = mem_ack ? rdata : $urandom;
            #1;
            chk("req_mem_req", mem_req, 1'b1);
            chk("req_mem_addr", mem_addr, aligned);
            chk("req_stall", stall, 1'b1);
            chk("req_no_rd_valid", rd_valid, 1'b0);
            if (mem_ack) break;
            if (c < TO) tick();
        end
        tick();
        mem_ack = 1'b0;
        #1;
        if (!exp_to) begin
            exp_q.push_back(exp_data);
            exp = exp_q.pop_front();
            chk("done_rd_valid", rd_valid, 1'b1);
            chk("done_rd_data", rd_data, exp);
            chk("done_no_timeout", timeout, 1'b0);
            chk("done_stall", stall, 1'b0);
            chk("done_ld_ready", ld_ready, 1'b0);
            chk("done_mem_req", mem_req, 1'b0);
            last_rd = exp;
        end else begin
            chk("timeout_pulse", timeout, 1'b1);
            chk("timeout_no_rd_valid", rd_valid, 1'b0);
            chk("timeout_mem_req", mem_req, 1'b0);
            chk("timeout_rd_hold", rd_data, last_rd);
            chk("timeout_ld_ready", ld_ready, 1'b1);
        end
        tick();
        chk("after_rd_valid", rd_valid, 1'b0);
        chk("after_timeout", timeout, 1'b0);
        chk("after_state", fsm_state, ST_IDLE);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{32'h1003, 2'd0, 1'b1, 32'h80FF_1234, 2,  32'h0000_0080, 1'b0, 1'b0};
        vecs[1]  = '{32'h1003, 2'd0, 1'b0, 32'h80FF_1234, 0,  32'hFFFF_FF80, 1'b0, 1'b0};
        vecs[2]  = '{32'h1000, 2'd0, 1'b0, 32'h80FF_1234, 1,  32'h0000_0034, 1'b0, 1'b0};
        vecs[3]  = '{32'h1001, 2'd0, 1'b0, 32'h1234_5678, 0,  32'h0000_0056, 1'b0, 1'b0};
        vecs[4]  = '{32'h2002, 2'd1, 1'b0, 32'h8001_0000, 3,  32'hFFFF_8001, 1'b0, 1'b0};
        vecs[5]  = '{32'h2002, 2'd1, 1'b1, 32'h8001_0000, 0,  32'h0000_8001, 1'b0, 1'b0};
        vecs[6]  = '{32'h2000, 2'd2, 1'b0, 32'h8001_0000, 0,  32'h8001_0000, 1'b0, 1'b0};
        vecs[7]  = '{32'h2000, 2'd1, 1'b1, 32'h1234_FFFE, 1,  32'h0000_FFFE, 1'b0, 1'b0};
        vecs[8]  = '{32'h2004, 2'd2, 1'b1, 32'h8000_0000, 0,  32'h8000_0000, 1'b0, 1'b0};
        vecs[9]  = '{32'h3001, 2'd2, 1'b0, 32'h0,         0,  32'h0,         1'b1, 1'b0};
        vecs[10] = '{32'h3001, 2'd1, 1'b0, 32'h0,         0,  32'h0,         1'b1, 1'b0};
        vecs[11] = '{32'h3000, 2'd3, 1'b0, 32'h0,         0,  32'h0,         1'b1, 1'b0};
        vecs[12] = '{32'h3002, 2'd2, 1'b0, 32'h0,         0,  32'h0,         1'b1, 1'b0};
        vecs[13] = '{32'h4000, 2'd2, 1'b0, 32'hDEAD_BEEF, TO, 32'h0,         1'b0, 1'b1};
        vecs[14] = '{32'h4000, 2'd2, 1'b0, 32'hCAFE_F00D, 15, 32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[15] = '{32'h4003, 2'd0, 1'b0, 32'h7F00_0000, 14, 32'h0000_007F, 1'b0, 1'b0};
    end

    initial begin
        rst         = 1'b1;
        ld_valid    = 1'b0;
        ld_addr     = '0;
        ld_size     = 2'd0;
        ld_unsigned = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        last_rd     = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_misalign", misalign, 1'b0);
        chk("reset_timeout", timeout, 1'b0);
        chk("reset_ld_ready", ld_ready, 1'b1);
        chk("reset_stall", stall, 1'b0);

        for (int i = 0; i < 16; i++) begin
            do_load(vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].rdata, vecs[i].waits,
                    vecs[i].exp_data, vecs[i].exp_mis, vecs[i].exp_to);
        end

        // Held ld_valid through DONE must not start a second load.
        tick();
        ld_valid = 1'b1; ld_addr = 32'h6000; ld_size = 2'd2; ld_unsigned = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
        #1;
        chk("held_req", mem_req, 1'b1);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("held_rd_valid", rd_valid, 1'b1);
        chk("held_rd_data", rd_data, 32'h1357_9BDF);
        chk("held_ld_ready", ld_ready, 1'b0);
        chk("held_stall", stall, 1'b0);
        last_rd = 32'h1357_9BDF;
        tick();
        ld_valid = 1'b0;
        #1;
        chk("held_no_reaccept", mem_req, 1'b0);
        chk("held_idle", fsm_state, ST_IDLE);

        // Reset in the middle of REQ abandons the load; ack around it is ignored.
        tick();
        ld_valid = 1'b1; ld_addr = 32'h5000; ld_size = 2'd2;
        tick();
        ld_valid = 1'b0;
        #1;
        chk("rst_pre_req", mem_req, 1'b1);
        tick();
        tick();
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_mem_req", mem_req, 1'b0);
        chk("rst_mid_mem_addr", mem_addr, 32'h0);
        chk("rst_mid_rd_valid", rd_valid, 1'b0);
        chk("rst_mid_rd_data", rd_data, 32'h0);
        chk("rst_mid_timeout", timeout, 1'b0);
        chk("rst_mid_misalign", misalign, 1'b0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("rst_ack_ignored", rd_valid, 1'b0);
        chk("rst_ack_no_req", mem_req, 1'b0);
        last_rd = 32'h0;
        do_load(32'h5000, 2'd2, 1'b0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 1'b0, 1'b0);

        // Random loads against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [1:0]  s;
            logic        u;
            logic [31:0] d;
            int          w;
            logic        lg;
            logic        to;
            a  = {16'h0, $urandom_range(0, 32'hFFFF)};
            s  = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            d  = $urandom;
            w  = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, 4);
            lg = ref_legal(a, s);
            to = lg && (w >= TO);
            do_load(a, s, u, d, w, (lg && !to) ? ref_load(a, s, u, d) : last_rd, !lg, to);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
